// File: rtl/tcm_dport_pkg.sv
// rtl/tcm_dport_pkg.sv - shared types and constants for the TCM data-port buffer
//
// Purpose : request payload layout and op-class decode used by tcm_dport_buf.
// Contents: DPORT_TAG_W, OP_RD / OP_WR / OP_CMO, dport_req_t, dport_op_class().

package tcm_dport_pkg;

    localparam int DPORT_TAG_W = 11;

    // Op-class encoding carried from the FIFO head into the issue stage.
    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_CMO = 2'd2;

    typedef struct packed {
        logic [31:0]            addr;
        logic [31:0]            wdata;
        logic [3:0]             be;
        logic                   rd;
        logic                   cmo;
        logic [DPORT_TAG_W-1:0] tag;
    } dport_req_t;

    // Any byte enable makes the request a write, even if rd is also set.
    // A request with neither is a cache-maintenance op, which has no SRAM access.
    function automatic logic [1:0] dport_op_class(input dport_req_t req);
        logic [1:0] op;
        if (req.be != 4'b0000) begin
            op = OP_WR;
        end else if (req.rd) begin
            op = OP_RD;
        end else begin
            op = OP_CMO;
        end
        return op;
    endfunction

endpackage

// File: rtl/dport_req_fifo.sv
// rtl/dport_req_fifo.sv - generic synchronous request FIFO
//
// Purpose : DEPTH-entry, WIDTH-bit FIFO with registered occupancy count.
// Ports   : clk, rst (async, active-high)
//           push, push_data  - write side; ignored when full
//           pop, pop_data    - read side; pop_data is the head, ignored when empty
//           count, full, empty
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.

module dport_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push_en;
    logic pop_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tcm_dport_buf.sv
// rtl/tcm_dport_buf.sv - buffered core data port in front of a single-port TCM SRAM
//
// Purpose : queues mem_d_* requests, issues one per cycle to the SRAM from
//           registered outputs, and returns ack / read data / tag in order.
// Ports   : clk, rst (async, active-high)
//           mem_d_*  - core data interface (request in, accept/ack/response out)
//           sram_*   - SRAM macro interface; sram_rdata_i valid the cycle after cs
// Optional: define TCM_DPORT_RANGE_CHECK_EN to reject addresses outside
//           [BASE_ADDR, BASE_ADDR + 2^(AW+2)) with error_o instead of aliasing.
// Latency : accepted at edge N -> SRAM strobe in cycle N+1 -> ack in cycle N+2.

module tcm_dport_buf
    import tcm_dport_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          AW        = 15,
    parameter int          TAG_W     = DPORT_TAG_W,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       mem_d_addr_i,
    input  logic [31:0]       mem_d_data_wr_i,
    input  logic              mem_d_rd_i,
    input  logic [3:0]        mem_d_wr_i,
    input  logic              mem_d_cacheable_i,
    input  logic [TAG_W-1:0]  mem_d_req_tag_i,
    input  logic              mem_d_invalidate_i,
    input  logic              mem_d_writeback_i,
    input  logic              mem_d_flush_i,
    output logic              mem_d_accept_o,
    output logic              mem_d_ack_o,
    output logic              mem_d_error_o,
    output logic [31:0]       mem_d_data_rd_o,
    output logic [TAG_W-1:0]  mem_d_resp_tag_o,

    output logic              sram_cs_o,
    output logic [3:0]        sram_we_o,
    output logic [AW-1:0]     sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int REQ_W = $bits(dport_req_t);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic             req_valid;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    dport_req_t       push_req;
    dport_req_t       head_req;
    logic [REQ_W-1:0] fifo_rd_data;

    assign req_valid = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                     | mem_d_writeback_i | mem_d_flush_i;

    // Accept is purely from the registered count, so the core never sees a
    // combinational path through the pop side.
    assign mem_d_accept_o = (fifo_count < CW'(DEPTH));
    assign fifo_push      = req_valid & mem_d_accept_o;

    // The SRAM never stalls, so the head drains every cycle it exists.
    assign fifo_pop       = ~fifo_empty;

    always_comb begin
        push_req       = '0;
        push_req.addr  = mem_d_addr_i;
        push_req.wdata = mem_d_data_wr_i;
        push_req.be    = mem_d_wr_i;
        push_req.rd    = mem_d_rd_i;
        push_req.cmo   = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
        // Tag field is sized by DPORT_TAG_W; TAG_W is expected to match it.
        push_req.tag   = DPORT_TAG_W'(mem_d_req_tag_i);
    end

    dport_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_req = fifo_rd_data;

    // ------------------------------------------------------------------
    // Head decode and address range check
    // ------------------------------------------------------------------
    logic [1:0]  head_op;
    logic        head_in_range;
    logic        head_err;
    logic [31:0] head_off;

    assign head_op  = dport_op_class(head_req);
    assign head_off = head_req.addr - BASE_ADDR;

`ifdef TCM_DPORT_RANGE_CHECK_EN
    // Offset from BASE_ADDR must fit in the SRAM byte span; addresses below
    // BASE_ADDR wrap to a huge offset and fail the same test.
    assign head_in_range = ((head_off >> (AW + 2)) == 32'd0);
    logic unused_bits;
    assign unused_bits = ^{mem_d_cacheable_i, fifo_full, head_req.cmo,
                           head_req.addr[1:0]};
`else
    // No range check: upper address bits are dropped and the SRAM aliases.
    assign head_in_range = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{mem_d_cacheable_i, fifo_full, head_req.cmo,
                           head_req.addr[1:0], head_req.addr[31:AW+2], head_off};
`endif

    // Cache-maintenance ops never touch the SRAM, so they are never flagged.
    assign head_err = ~head_in_range & (head_op != OP_CMO);

    // ------------------------------------------------------------------
    // Issue stage: registered SRAM strobe
    // ------------------------------------------------------------------
    logic              iss_vld_q,    iss_vld_d;
    logic [1:0]        iss_op_q,     iss_op_d;
    logic              iss_err_q,    iss_err_d;
    logic [TAG_W-1:0]  iss_tag_q,    iss_tag_d;
    logic              sram_cs_q,    sram_cs_d;
    logic [3:0]        sram_we_q,    sram_we_d;
    logic [AW-1:0]     sram_addr_q,  sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;

    always_comb begin
        iss_vld_d    = 1'b0;
        iss_op_d     = OP_CMO;
        iss_err_d    = 1'b0;
        iss_tag_d    = '0;
        sram_cs_d    = 1'b0;
        sram_we_d    = 4'b0000;
        sram_addr_d  = '0;
        sram_wdata_d = '0;
        if (fifo_pop) begin
            iss_vld_d    = 1'b1;
            iss_op_d     = head_op;
            iss_err_d    = head_err;
            iss_tag_d    = TAG_W'(head_req.tag);
            sram_cs_d    = (head_op != OP_CMO) & ~head_err;
            sram_we_d    = (head_op == OP_WR && !head_err) ? head_req.be : 4'b0000;
            sram_addr_d  = head_req.addr[AW+1:2];
            sram_wdata_d = head_req.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_vld_q    <= 1'b0;
            iss_op_q     <= OP_CMO;
            iss_err_q    <= 1'b0;
            iss_tag_q    <= '0;
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 4'b0000;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            iss_vld_q    <= iss_vld_d;
            iss_op_q     <= iss_op_d;
            iss_err_q    <= iss_err_d;
            iss_tag_q    <= iss_tag_d;
            sram_cs_q    <= sram_cs_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign sram_cs_o    = sram_cs_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_wdata_o = sram_wdata_q;

    // ------------------------------------------------------------------
    // Response stage
    // ------------------------------------------------------------------
    logic             rsp_ack_q, rsp_ack_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_rd_q,  rsp_rd_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    always_comb begin
        rsp_ack_d = iss_vld_q;
        rsp_err_d = iss_vld_q & iss_err_q;
        rsp_rd_d  = iss_vld_q & (iss_op_q == OP_RD) & ~iss_err_q;
        rsp_tag_d = iss_vld_q ? iss_tag_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_ack_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
            rsp_tag_q <= '0;
        end else begin
            rsp_ack_q <= rsp_ack_d;
            rsp_err_q <= rsp_err_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    // SRAM read data arrives in the ack cycle, so it is steered straight out
    // rather than registered again, keeping the two-cycle latency.
    assign mem_d_ack_o      = rsp_ack_q;
    assign mem_d_error_o    = rsp_err_q;
    assign mem_d_resp_tag_o = rsp_tag_q;
    assign mem_d_data_rd_o  = rsp_rd_q ? sram_rdata_i : 32'd0;

endmodule

// File: doc/tcm_dport_buf.md
Name: tcm_dport_buf

Overview:
- Buffered data-port stage between the RISC-V core data interface (mem_d_*) and a single-port word-wide TCM SRAM macro.
- Queues core requests in a small FIFO and issues one per cycle to the SRAM.
- Returns ack, read data and the echoed request tag in issue order.
- Replaces direct core-to-memory wiring so the SRAM sees registered, back-pressure-free timing.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, >=2)
- AW, 15, SRAM word-address width (2^15 words = 128 KiB)
- TAG_W, 11, request/response tag width
- BASE_ADDR, 32'h80000000, byte address mapped to SRAM word 0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_d_addr_i  in  32  request byte address
- mem_d_data_wr_i  in  32  write data
- mem_d_rd_i  in  1  read request
- mem_d_wr_i  in  4  byte-write enables; nonzero = write
- mem_d_cacheable_i  in  1  ignored, no cache
- mem_d_req_tag_i  in  TAG_W  request tag
- mem_d_invalidate_i / mem_d_writeback_i / mem_d_flush_i  in  1 each  cache-maintenance ops (CMO)
- mem_d_accept_o  out  1  request taken this cycle
- mem_d_ack_o  out  1  response valid, single-cycle pulse
- mem_d_error_o  out  1  response error
- mem_d_data_rd_o  out  32  read data
- mem_d_resp_tag_o  out  TAG_W  tag of the responding request
- sram_cs_o  out  1  SRAM access strobe
- sram_we_o  out  4  SRAM byte write enables
- sram_addr_o  out  AW  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid the cycle after cs

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-high, on rst.
- Reset values: all outputs 0 except mem_d_accept_o, which is 1 (FIFO empty).
- A request is any of: rd, wr!=0, invalidate, writeback, flush.
- accept_o = (count < DEPTH). Combinational from the registered count; it does not depend on a same-cycle pop.
- Push: request && accept_o at a clock edge enqueues {addr, wdata, be, rd, cmo, tag}.
- Request while full: not accepted. The core holds it; the FIFO is unchanged.
- rd and wr both set: treated as a write.
- Issue: when the FIFO is non-empty, pop the head each cycle into registered SRAM outputs.
  - Write: cs=1, we=be.
  - Read: cs=1, we=0.
  - CMO: cs=0.
  - addr = addr[AW+1:2].
- Response: registered one cycle after issue.
  - ack_o=1 and resp_tag_o = the tag.
  - data_rd_o = sram_rdata_i for reads, 0 for writes and CMOs.
  - error_o=0 unless the optional feature flags it.
- Latency: request accepted at edge N, SRAM strobe during cycle N+1, ack during cycle N+2. Throughput is 1 per cycle.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Ordering: responses strictly in request order. At most 2 requests are in flight beyond the FIFO (issue stage and response stage).
- Reset mid-operation: FIFO emptied, in-flight SRAM access and pending ack discarded, no ack after reset deasserts.

Optional Feature:
- Macro: TCM_DPORT_RANGE_CHECK_EN.
- Defined: at issue, addresses outside [BASE_ADDR, BASE_ADDR + 2^(AW+2)) get cs=0 and we=0, and the response carries error_o=1 and data_rd_o=0 with normal latency. CMOs are never flagged.
- Undefined: no range comparison. Upper address bits are ignored, so the SRAM aliases. error_o is tied 0.

Decomposition:
- Package tcm_dport_pkg:
  - typedef dport_req_t {addr[31:0], wdata[31:0], be[3:0], rd, cmo, tag[TAG_W-1:0]}
  - DPORT_TAG_W=11 constant
  - op-class encoding constants OP_RD, OP_WR, OP_CMO
- Sub-module dport_req_fifo: generic synchronous FIFO with parameters DEPTH and payload width, outputs count/full/empty.
- tcm_dport_buf holds the issue stage, response stage and range check.

Test Plan:
- Single read:
  - Preload SRAM word 0x10 = 0xDEADBEEF.
  - Stimulus: rd at addr 0x80000040, tag 0x3A5.
  - Response: cs=1 and addr=0x10 two edges later; ack with data 0xDEADBEEF and tag 0x3A5 at cycle N+2.
- Byte write then read-back:
  - Write 0x11223344 with be=4'b0010 to 0x80000008, then read it.
  - Response: we=4'b0010 on the SRAM; read returns only byte1 = 0x33 changed; acks in order.
- Back-pressure:
  - Stimulus: 6 back-to-back writes with tags 1..6 while the SRAM model stalls nothing.
  - Response: accept never drops.
  - Stimulus: hold one pop disabled via a forced full scenario with 4 queued.
  - Response: accept_o=0 and the held request enters after the next pop.
  - All 6 acks in tag order.
- CMO:
  - Stimulus: flush with tag 0x7FF between two reads.
  - Response: no cs for it; ack with tag 0x7FF and data 0, between the two read acks.
- Reset mid-stream:
  - Stimulus: 3 requests queued, assert rst for 1 cycle.
  - Response: no further acks; accept_o=1; SRAM outputs 0.
- Range check (with TCM_DPORT_RANGE_CHECK_EN):
  - Stimulus: read 0x90000000.
  - Response: no cs; ack with error=1 and data 0.
  - Without the macro: error=0 and aliases to word 0.
